// File: rtl/bl_mux_pkg.sv
// Shared types and helpers for the BL_MUX channel-scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: NUM_CH/CH_W geometry, scan FSM state enum, lowest-set-bit and max helpers.
package bl_mux_pkg;

   localparam int NUM_CH = 8;
   localparam int CH_W   = 3;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BBM    = 3'd1,
      SETTLE = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } scan_state_t;

   // Index of the lowest set bit; 0 when the mask is empty (callers qualify).
   function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] mask);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (mask[i]) idx = CH_W'(i);
      end
      return idx;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/bl_mux_chan_sel.sv
// Next-channel finder: lowest enabled channel strictly above cur, else wraps.
// Latency: combinational.
// Backpressure: none.
// Ports: mask (enabled channels), cur (current channel), wrap (allow wrap to lowest)
//        -> nxt (selected channel), found (a channel was selected).
module bl_mux_chan_sel
   import bl_mux_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur,
   input  logic              wrap,
   output logic [CH_W-1:0]   nxt,
   output logic              found
);

   logic [NUM_CH-1:0] above;

   always_comb begin
      above = '0;
      nxt   = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         above[i] = mask[i] && (i > int'(cur));
      end
      if (above != '0) begin
         nxt   = lowest_set(above);
         found = 1'b1;
      end else if (wrap && (mask != '0)) begin
         // Wrapping may land back on cur for a single-channel mask.
         nxt   = lowest_set(mask);
         found = 1'b1;
      end
   end

endmodule

// File: rtl/bl_mux_scan_ctrl.sv
// Scans enabled ADG1408 channels: break-before-make, settle, then one ADC req/ack per channel.
// Latency: start -> mux_en 1+BBM_CYCLES; mux_en -> sample_req SETTLE_CYCLES; outputs registered.
// Backpressure: sample_req held until sample_ack (or timeout when BL_MUX_SCAN_TIMEOUT_EN is defined).
// Ports: clk, Reset (async, active-high), start/stop/continuous/ch_mask control, sample_ack from ADC;
//        mux_en/mux_a to BL_MUX, sample_req/ch_id to ADC, busy/done/timeout_err status.
// Option: define BL_MUX_SCAN_TIMEOUT_EN to abandon an unacked sample after TIMEOUT_CYCLES.
module bl_mux_scan_ctrl
   import bl_mux_pkg::*;
#(
   parameter int BBM_CYCLES     = 4,
   parameter int SETTLE_CYCLES  = 50,
   parameter int TIMEOUT_CYCLES = 1024
)(
   input  logic              clk,
   input  logic              Reset,
   input  logic              start,
   input  logic              stop,
   input  logic              continuous,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              sample_ack,
   output logic              mux_en,
   output logic [CH_W-1:0]   mux_a,
   output logic              sample_req,
   output logic [CH_W-1:0]   ch_id,
   output logic              busy,
   output logic              done,
   output logic              timeout_err
);

`ifdef BL_MUX_SCAN_TIMEOUT_EN
   localparam int CNT_MAX = max_int(max_int(BBM_CYCLES, SETTLE_CYCLES), TIMEOUT_CYCLES);
`else
   localparam int CNT_MAX = max_int(BBM_CYCLES, SETTLE_CYCLES);
`endif
   localparam int CNT_W = $clog2(CNT_MAX + 1);

   scan_state_t       state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [NUM_CH-1:0] mask_q;
   logic              cont_q;
   logic              stop_pend_q;

   logic              start_ok;
   logic              cnt_zero;
   logic              tmo_hit;
   logic              adv;
   logic [CH_W-1:0]   nxt_ch;
   logic              nxt_found;

   logic              mux_en_d, sample_req_d, busy_d, done_d;
   logic [CH_W-1:0]   mux_a_d;

   // stop has priority over a simultaneous start.
   assign start_ok = start && !stop;
   assign cnt_zero = (cnt_q == '0);

`ifdef BL_MUX_SCAN_TIMEOUT_EN
   assign tmo_hit = (state_q == SAMPLE) && !sample_ack && cnt_zero;
`else
   assign tmo_hit = 1'b0;
`endif

   // A timed-out sample advances exactly as if it had been acknowledged.
   assign adv = sample_ack || tmo_hit;

   bl_mux_chan_sel u_chan_sel (
      .mask  (mask_q),
      .cur   (mux_a),
      .wrap  (cont_q),
      .nxt   (nxt_ch),
      .found (nxt_found)
   );

   // State register.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (start_ok && (ch_mask != '0)) state_d = BBM;
         BBM:    if (stop) state_d = DONE;
                 else if (cnt_zero) state_d = SETTLE;
         SETTLE: if (stop) state_d = DONE;
                 else if (cnt_zero) state_d = SAMPLE;
         // A request is never withdrawn: stop only takes effect once the sample completes.
         SAMPLE: if (adv) state_d = (stop || stop_pend_q || !nxt_found) ? DONE : BBM;
         DONE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode of the upcoming state; registered below so outputs align with state_q.
   always_comb begin
      mux_en_d     = (state_d == SETTLE) || (state_d == SAMPLE);
      sample_req_d = (state_d == SAMPLE);
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE) ||
                     ((state_q == IDLE) && start_ok && (ch_mask == '0));
      mux_a_d      = mux_a;
      // Address only moves on BBM entry, the same edge that drops mux_en.
      if ((state_q == IDLE) && (state_d == BBM))
         mux_a_d = lowest_set(ch_mask);
      else if ((state_q == SAMPLE) && (state_d == BBM))
         mux_a_d = nxt_ch;
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         cnt_q       <= '0;
         mask_q      <= '0;
         cont_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         mux_en      <= 1'b0;
         mux_a       <= '0;
         sample_req  <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         // Shared down-counter, reloaded on every state entry.
         if (state_d != state_q) begin
            case (state_d)
               BBM:     cnt_q <= CNT_W'(BBM_CYCLES - 1);
               SETTLE:  cnt_q <= CNT_W'(SETTLE_CYCLES - 1);
`ifdef BL_MUX_SCAN_TIMEOUT_EN
               SAMPLE:  cnt_q <= CNT_W'(TIMEOUT_CYCLES - 1);
`endif
               default: cnt_q <= '0;
            endcase
         end else if (!cnt_zero) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         if ((state_q == IDLE) && start_ok && (ch_mask != '0)) begin
            mask_q <= ch_mask;
            cont_q <= continuous;
         end

         // Remember a stop seen while waiting for ack.
         if ((state_q == SAMPLE) && (state_d == SAMPLE))
            stop_pend_q <= stop_pend_q || stop;
         else
            stop_pend_q <= 1'b0;

         mux_en     <= mux_en_d;
         mux_a      <= mux_a_d;
         sample_req <= sample_req_d;
         busy       <= busy_d;
         done       <= done_d;
      end
   end

   assign ch_id = mux_a;

`ifdef BL_MUX_SCAN_TIMEOUT_EN
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset)
         timeout_err <= 1'b0;
      else if ((state_q == IDLE) && start_ok)
         timeout_err <= 1'b0;
      else if (tmo_hit)
         timeout_err <= 1'b1;
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule
